alu_seq: RTL

//  Parametrised, registered successor to the 4-bit add/sub/compare/AND unit.

---
 rtl/alu_seq.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes: single-cycle add/sub/compare/logic ops
// and a WIDTH-cycle shift-add multiply, with output backpressure.
module alu_seq #(
   parameter int WIDTH      = 4,
   parameter bit SIGNED_CMP = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [2:0]           op,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   result,
   output logic                 carry,
   output logic                 eq,
   output logic                 less,
   output logic                 great,
   output logic                 err,
   output logic                 busy
);

   localparam int RW = 2 * WIDTH;
   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_CMP = 3'b010;
   localparam logic [2:0] OP_AND = 3'b011;
   localparam logic [2:0] OP_OR  = 3'b100;
   localparam logic [2:0] OP_XOR = 3'b101;
   localparam logic [2:0] OP_MUL = 3'b110;

   typedef enum logic {
      S_IDLE,
      S_MUL
   } state_t;

   state_t state, state_next;

   logic              accept;
   logic              mul_start;
   logic              mul_last;
   logic [RW-1:0]     mul_acc;
   logic [RW-1:0]     mul_mcand;
   logic [RW-1:0]     mul_sum;
   logic [WIDTH-1:0]  mul_mplier;
   logic [WIDTH-1:0]  mul_a;
   logic [WIDTH-1:0]  mul_b;
   logic [CW-1:0]     mul_count;

   logic [WIDTH:0]    add_sum;
   logic [WIDTH-1:0]  sub_diff;
   logic [RW-1:0]     alu_result;
   logic              alu_carry;
   logic              alu_err;
   logic [2:0]        alu_cmp;

   // Returns {eq, less, great}; the signedness is fixed at elaboration
   function automatic logic [2:0] compare(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
      logic lt;
      logic gt;
      if (SIGNED_CMP) begin
         lt = $signed(x) < $signed(y);
         gt = $signed(x) > $signed(y);
      end else begin
         lt = x < y;
         gt = x > y;
      end
      return {x == y, lt, gt};
   endfunction

   // in_ready is held low during reset so nothing is accepted while rst is asserted
   assign in_ready  = !rst && (state == S_IDLE) && (!out_valid || out_ready);
   assign accept    = in_valid && in_ready;
   assign mul_start = accept && (op == OP_MUL);
   assign mul_last  = (state == S_MUL) && (mul_count == CW'(WIDTH - 1));
   assign busy      = (state == S_MUL);
   assign mul_sum   = mul_acc + (mul_mplier[0] ? mul_mcand : '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: if (mul_start) state_next = S_MUL;
         S_MUL:  if (mul_last)  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // Single-cycle operations evaluated directly from the inputs presented at accept
   always_comb begin
      add_sum    = {1'b0, a} + {1'b0, b};
      sub_diff   = a - b;
      alu_result = '0;
      alu_carry  = 1'b0;
      alu_err    = 1'b0;
      alu_cmp    = compare(a, b);
      case (op)
         OP_ADD: begin
            alu_result = RW'(add_sum);
            alu_carry  = add_sum[WIDTH];
         end
         OP_SUB: begin
            alu_result = RW'(sub_diff);
            alu_carry  = (a < b);
         end
         OP_CMP: alu_result = '0;
         OP_AND: alu_result = RW'(a & b);
         OP_OR:  alu_result = RW'(a | b);
         OP_XOR: alu_result = RW'(a ^ b);
         OP_MUL: alu_result = '0;
         default: begin
            alu_err = 1'b1;
            alu_cmp = 3'b000;
         end
      endcase
   end

   // Shift-add multiplier: one partial product folded in per cycle, LSB of b first
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mul_acc    <= '0;
         mul_mcand  <= '0;
         mul_mplier <= '0;
         mul_a      <= '0;
         mul_b      <= '0;
         mul_count  <= '0;
      end else if (mul_start) begin
         mul_acc    <= '0;
         mul_mcand  <= RW'(a);
         mul_mplier <= b;
         mul_a      <= a;
         mul_b      <= b;
         mul_count  <= '0;
      end else if (state == S_MUL) begin
         mul_acc    <= mul_sum;
         mul_mcand  <= mul_mcand << 1;
         mul_mplier <= mul_mplier >> 1;
         mul_count  <= mul_count + CW'(1);
      end
   end

   // Output register: values persist after drain, only out_valid drops
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         result    <= '0;
         carry     <= 1'b0;
         eq        <= 1'b0;
         less      <= 1'b0;
         great     <= 1'b0;
         err       <= 1'b0;
      end else if (mul_last) begin
         out_valid          <= 1'b1;
         result             <= mul_sum;
         carry              <= 1'b0;
         {eq, less, great}  <= compare(mul_a, mul_b);
         err                <= 1'b0;
      end else if (accept && !mul_start) begin
         out_valid          <= 1'b1;
         result             <= alu_result;
         carry              <= alu_carry;
         {eq, less, great}  <= alu_cmp;
         err                <= alu_err;
      end else if (mul_start) begin
         out_valid <= 1'b0;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
